// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch: streams one framebuffer per frame from a valid/ready
// memory port into a small prefetch FIFO. It drives registered RGB, syncs
// and blank, one cycle behind the sync generator outputs.
module vga_pixel_fetch #(
  parameter int unsigned COLORW       = 8,
  parameter int unsigned FRAME_PIXELS = 307200,
  parameter int unsigned ADDRW        = 19,
  parameter int unsigned BASE_ADDR    = 0,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                  vga_clk,
  input  logic                  rst,
  input  logic                  vga_hsync_in,
  input  logic                  vga_vsync_in,
  input  logic                  vga_video_on_in,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDRW-1:0]      mem_req_addr,
  input  logic                  mem_rsp_valid,
  input  logic [3*COLORW-1:0]   mem_rsp_data,
  output logic [COLORW-1:0]     vga_r,
  output logic [COLORW-1:0]     vga_g,
  output logic [COLORW-1:0]     vga_b,
  output logic                  vga_hsync,
  output logic                  vga_vsync,
  output logic                  vga_blank_n,
  output logic                  underflow,
  output logic                  underflow_sticky
);

  localparam int unsigned PIXW = 3 * COLORW;
  localparam int unsigned PTRW = $clog2(FIFO_DEPTH);
  localparam int unsigned CNTW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned REQW = $clog2(FRAME_PIXELS + 1);

  localparam logic [ADDRW-1:0] BASE      = ADDRW'(BASE_ADDR);
  localparam logic [REQW-1:0]  FRAME_CNT = REQW'(FRAME_PIXELS);
  localparam logic [CNTW:0]    DEPTH_LIM = (CNTW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_FETCH,
    ST_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              req_valid_q, req_valid_d;
  logic [ADDRW-1:0]  req_addr_q, req_addr_d;
  logic [REQW-1:0]   req_cnt_q, req_cnt_d;
  logic [CNTW-1:0]   outstanding_q, outstanding_d;
  logic [CNTW-1:0]   count_q, count_d;
  logic [PTRW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PIXW-1:0]   fifo_mem_q [FIFO_DEPTH];
  logic [PIXW-1:0]   rgb_q, rgb_d;
  logic              hsync_q, hsync_d;
  logic              vsync_q, vsync_d;
  logic              blank_n_q, blank_n_d;
  logic              underflow_q, underflow_d;
  logic              sticky_q, sticky_d;

  logic              fs;
  logic              accept;
  logic              in_fetch;
  logic              rsp_take;
  logic              push;
  logic              pop;
  logic              flush_exit;
  logic              credit_ok;
  logic              more_to_fetch;

  // Next-state logic for the fetch FSM, credit accounting, FIFO pointers and outputs
  always_comb begin
    // vsync_q doubles as the delayed vsync output and the edge-detect register
    fs         = vsync_q & ~vga_vsync_in;
    accept     = req_valid_q & mem_req_ready;
    in_fetch   = (state_q == ST_FETCH) || (state_q == ST_DONE);
    // Responses with nothing outstanding are stale (issued before a reset)
    rsp_take   = mem_rsp_valid & (outstanding_q != '0);
    push       = rsp_take & in_fetch;
    pop        = vga_video_on_in & in_fetch & (count_q != '0);
    flush_exit = (state_q == ST_FLUSH) && (outstanding_q == '0) && !req_valid_q;

    outstanding_d = outstanding_q;
    if (accept && !rsp_take) begin
      outstanding_d = outstanding_q + CNTW'(1);
    end else if (!accept && rsp_take) begin
      outstanding_d = outstanding_q - CNTW'(1);
    end

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNTW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CNTW'(1);
    end

    wr_ptr_d   = push ? wr_ptr_q + PTRW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PTRW'(1) : rd_ptr_q;
    req_addr_d = accept ? req_addr_q + ADDRW'(1) : req_addr_q;
    req_cnt_d  = accept ? req_cnt_q + REQW'(1) : req_cnt_q;

    underflow_d = vga_video_on_in & ~pop;
    sticky_d    = sticky_q | underflow_d;
    state_d     = state_q;

    unique case (state_q)
      ST_IDLE: begin
        if (fs) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (flush_exit) begin
          state_d    = ST_FETCH;
          count_d    = '0;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          req_addr_d = BASE;
          req_cnt_d  = '0;
          sticky_d   = 1'b0;
        end
      end
      ST_FETCH, ST_DONE: begin
        if (fs) state_d = ST_FLUSH;
      end
      default: state_d = ST_IDLE;
    endcase

    // Credit uses next-cycle occupancy so a new request can follow an accept back-to-back
    credit_ok     = ({1'b0, count_d} + {1'b0, outstanding_d}) < DEPTH_LIM;
    more_to_fetch = req_cnt_d < FRAME_CNT;
    req_valid_d   = (req_valid_q & ~mem_req_ready) |
                    ((state_q == ST_FETCH) & ~fs & credit_ok & more_to_fetch);

    if ((state_q == ST_FETCH) && !fs && !more_to_fetch && !req_valid_d) begin
      state_d = ST_DONE;
    end

    rgb_d     = pop ? fifo_mem_q[rd_ptr_q] : '0;
    hsync_d   = vga_hsync_in;
    vsync_d   = vga_vsync_in;
    blank_n_d = vga_video_on_in;
  end

  // State, control and output registers with synchronous reset
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      req_valid_q   <= 1'b0;
      req_addr_q    <= BASE;
      req_cnt_q     <= '0;
      outstanding_q <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      rgb_q         <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      blank_n_q     <= 1'b0;
      underflow_q   <= 1'b0;
      sticky_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_valid_q   <= req_valid_d;
      req_addr_q    <= req_addr_d;
      req_cnt_q     <= req_cnt_d;
      outstanding_q <= outstanding_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      rgb_q         <= rgb_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      blank_n_q     <= blank_n_d;
      underflow_q   <= underflow_d;
      sticky_q      <= sticky_d;
    end
  end

  // Prefetch storage; contents need no reset since occupancy is tracked separately
  always_ff @(posedge vga_clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= mem_rsp_data;
    end
  end

  assign mem_req_valid    = req_valid_q;
  assign mem_req_addr     = req_addr_q;
  assign vga_r            = rgb_q[PIXW-1 -: COLORW];
  assign vga_g            = rgb_q[2*COLORW-1 -: COLORW];
  assign vga_b            = rgb_q[COLORW-1:0];
  assign vga_hsync        = hsync_q;
  assign vga_vsync        = vsync_q;
  assign vga_blank_n      = blank_n_q;
  assign underflow        = underflow_q;
  assign underflow_sticky = sticky_q;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Scoreboard bench for vga_pixel_fetch on a reduced raster (128 pixels/frame).
// The driver pushes one expectation record per cycle; the monitor pops and
// checks the registered outputs. The memory model returns data = address.
module tb_vga_pixel_fetch;

  localparam int COLORW = 8;
  localparam int FRAME  = 128;
  localparam int ADDRW  = 19;
  localparam int BASE   = 'h1000;
  localparam int DEPTH  = 16;

  localparam int HVIS = 16, HTOT = 48, HS_BEG = 22, HS_END = 28;
  localparam int VS_LINES = 2, VVIS_BEG = 4, VVIS_END = 12, VTOT = 13;

  logic                vga_clk = 1'b0;
  logic                rst = 1'b1;
  logic                vga_hsync_in = 1'b1, vga_vsync_in = 1'b1, vga_video_on_in = 1'b0;
  logic                mem_req_valid, mem_req_ready;
  logic [ADDRW-1:0]    mem_req_addr;
  logic                mem_rsp_valid;
  logic [3*COLORW-1:0] mem_rsp_data;
  logic [COLORW-1:0]   vga_r, vga_g, vga_b;
  logic                vga_hsync, vga_vsync, vga_blank_n, underflow, underflow_sticky;

  vga_pixel_fetch #(
    .COLORW(COLORW), .FRAME_PIXELS(FRAME), .ADDRW(ADDRW),
    .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)
  ) dut (
    .vga_clk(vga_clk), .rst(rst),
    .vga_hsync_in(vga_hsync_in), .vga_vsync_in(vga_vsync_in), .vga_video_on_in(vga_video_on_in),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_blank_n(vga_blank_n),
    .underflow(underflow), .underflow_sticky(underflow_sticky)
  );

  always #5 vga_clk = ~vga_clk;

  typedef struct {
    bit hs, vs, von, restart, allow_uf, rst;
    int sticky_chk;  // 0 none, 1 expect clear, 2 expect set
  } rec_t;
  rec_t exp_q[$];

  typedef struct {
    int due;
    logic [ADDRW-1:0] addr;
  } rsp_t;
  rsp_t rsp_q[$];

  int vectors = 0, miscompares = 0;
  int cyc = 0, ready_pct = 100, lat_min = 1, lat_max = 1;
  bit stall_arm = 0;
  int stall_until = 0;
  int uf_seen = 0;
  bit restart_pending = 1, prev_pending = 0;
  logic [ADDRW-1:0] exp_addr = ADDRW'(BASE), prev_addr = '0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Memory model: random/fixed ready, in-order responses with programmable latency
  initial begin
    rsp_t r;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    forever begin
      @(negedge vga_clk);
      cyc++;
      mem_req_ready = ($urandom_range(99) < ready_pct);
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
      if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
        if (stall_arm && rsp_q[0].addr == ADDRW'(BASE + 40)) begin
          stall_arm   = 0;
          stall_until = cyc + 60;
        end
        if (cyc >= stall_until) begin
          r = rsp_q.pop_front();
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = (3*COLORW)'(r.addr);
        end
      end
      #3;
      if (mem_req_valid && mem_req_ready) begin
        r.due  = cyc + int'($urandom_range(lat_max, lat_min));
        r.addr = mem_req_addr;
        rsp_q.push_back(r);
      end
      if (rst) begin
        prev_pending    = 0;
        restart_pending = 1;
      end else begin
        if (prev_pending)
          check("req_hold", {mem_req_valid, mem_req_addr}, {1'b1, prev_addr});
        if (mem_req_valid && mem_req_ready) begin
          check("req_addr", mem_req_addr,
                (restart_pending && mem_req_addr == ADDRW'(BASE)) ? ADDRW'(BASE) : exp_addr);
          check("req_range", (mem_req_addr < ADDRW'(BASE + FRAME)), 1);
          if (mem_req_addr == ADDRW'(BASE)) restart_pending = 0;
          exp_addr = mem_req_addr + ADDRW'(1);
        end
        prev_pending = mem_req_valid & ~mem_req_ready;
        prev_addr    = mem_req_addr;
      end
    end
  end

  // Monitor: one expectation record per cycle, compared one cycle after it was driven
  initial begin
    rec_t r;
    int pix_idx = 0;
    forever begin
      @(posedge vga_clk);
      #1;
      if (exp_q.size() > 0) begin
        r = exp_q.pop_front();
        check("credit", ((int'(dut.count_q) + int'(dut.outstanding_q)) <= DEPTH), 1);
        if (r.rst) begin
          check("rst_valid", mem_req_valid, 0);
          check("rst_addr", mem_req_addr, BASE);
          check("rst_rgb", {vga_r, vga_g, vga_b}, 0);
          check("rst_syncs", {vga_hsync, vga_vsync, vga_blank_n}, 3'b110);
          check("rst_uf", {underflow, underflow_sticky}, 0);
        end else begin
          if (r.restart) pix_idx = 0;
          check("hsync", vga_hsync, r.hs);
          check("vsync", vga_vsync, r.vs);
          check("blank_n", vga_blank_n, r.von);
          if (!r.von) begin
            check("blank_rgb", {vga_r, vga_g, vga_b}, 0);
            check("blank_uf", underflow, 0);
          end else if (underflow && r.allow_uf) begin
            uf_seen++;
            check("uf_rgb", {vga_r, vga_g, vga_b}, 0);
          end else begin
            check("uf", underflow, 0);
            check("pixel", {vga_r, vga_g, vga_b}, BASE + pix_idx);
            pix_idx++;
          end
          if (r.sticky_chk == 1) check("sticky_clear", underflow_sticky, 0);
          if (r.sticky_chk == 2) check("sticky_set", underflow_sticky, 1);
        end
      end
    end
  end

  task automatic drive(input bit hs, input bit vs, input bit von, input bit restart,
                       input bit allow_uf, input int sticky_chk);
    rec_t r;
    @(negedge vga_clk);
    rst = 1'b0;
    vga_hsync_in = hs;
    vga_vsync_in = vs;
    vga_video_on_in = von;
    if (restart) restart_pending = 1;
    r.hs = hs; r.vs = vs; r.von = von; r.restart = restart;
    r.allow_uf = allow_uf; r.rst = 0; r.sticky_chk = sticky_chk;
    exp_q.push_back(r);
  endtask

  task automatic drive_rst();
    rec_t r;
    @(negedge vga_clk);
    rst = 1'b1;
    vga_hsync_in = 1'b1; vga_vsync_in = 1'b1; vga_video_on_in = 1'b0;
    r = '{hs: 1, vs: 1, von: 0, restart: 0, allow_uf: 0, rst: 1, sticky_chk: 0};
    exp_q.push_back(r);
  endtask

  // One raster frame; abort_pix >= 0 stops just before that visible pixel
  task automatic run_frame(input bit allow_uf, input int abort_pix);
    int pix = 0;
    for (int line = 0; line < VTOT; line++) begin
      for (int h = 0; h < HTOT; h++) begin
        bit vs, hs, von;
        int sc;
        vs  = !(line < VS_LINES);
        hs  = !(h >= HS_BEG && h < HS_END);
        von = (line >= VVIS_BEG) && (line < VVIS_END) && (h < HVIS);
        sc  = 0;
        if (line == VVIS_BEG && h == 0) sc = 1;
        else if (allow_uf && line == VTOT - 1 && h == HTOT - 1) sc = 2;
        if (abort_pix >= 0 && von && pix == abort_pix) return;
        drive(hs, vs, von, (line == 0 && h == 0), allow_uf, sc);
        if (von) pix++;
      end
    end
  endtask

  task automatic reset_when_pending();
    rec_t r;
    bit got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge vga_clk);
      vga_hsync_in = 1'b1; vga_vsync_in = 1'b1; vga_video_on_in = 1'b0;
      #1;
      r = '{hs: 1, vs: 1, von: 0, restart: 0, allow_uf: 0, rst: 0, sticky_chk: 0};
      if (mem_req_valid) begin
        rst = 1'b1;
        r.rst = 1;
        got = 1;
      end
      exp_q.push_back(r);
    end
    check("pending_req_seen", got, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Test sequence
  initial begin
    repeat (3) @(posedge vga_clk);
    #1;
    check("init_valid", mem_req_valid, 0);
    check("init_addr", mem_req_addr, BASE);
    check("init_rgb", {vga_r, vga_g, vga_b}, 0);
    check("init_hsync", vga_hsync, 1);
    check("init_vsync", vga_vsync, 1);
    check("init_blank_n", vga_blank_n, 0);
    check("init_uf", underflow, 0);
    check("init_sticky", underflow_sticky, 0);

    // zero-latency memory
    ready_pct = 100; lat_min = 1; lat_max = 1;
    run_frame(0, -1);
    run_frame(0, -1);

    // random ready and latency
    ready_pct = 50; lat_min = 1; lat_max = 8;
    run_frame(0, -1);
    run_frame(0, -1);

    // response stall mid-frame, then a clean frame clears the sticky flag
    ready_pct = 100; lat_min = 4; lat_max = 4;
    stall_arm = 1;
    run_frame(1, -1);
    run_frame(0, -1);
    check("underflow_seen", (uf_seen > 0), 1);

    // frame start forced mid-frame with requests in flight
    lat_min = 8; lat_max = 8;
    run_frame(0, 60);
    run_frame(0, -1);

    // reset while fetching with a request pending, memory drains before next frame
    ready_pct = 50; lat_min = 1; lat_max = 8;
    run_frame(0, 30);
    reset_when_pending();
    drive_rst();
    repeat (40) drive(1, 1, 0, 0, 0, 0);
    run_frame(0, -1);

    repeat (10) drive(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge vga_clk);
    #2;
    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_pixel_fetch.md
Name: vga_pixel_fetch

Overview:
- Downstream stage of the VGA sync generator.
- Consumes its registered hsync/vsync/video_on and streams framebuffer pixels from a memory port with a valid/ready request and a variable-latency response.
- Buffers pixels in a small prefetch FIFO and drives RGB, delayed syncs and blank to the DAC, all aligned to one cycle after the sync inputs.
- Lives in the vga_clk domain; a single framebuffer is read linearly once per frame.

Parameters:
- COLORW, 8, bits per colour channel; pixel word is 3*COLORW, packed {R,G,B}.
- FRAME_PIXELS, 307200, pixels per frame (640x480).
- ADDRW, 19, memory address width; must satisfy 2^ADDRW >= BASE_ADDR+FRAME_PIXELS.
- BASE_ADDR, 0, framebuffer start address.
- FIFO_DEPTH, 16, prefetch FIFO entries; power of two, >= 4.

Ports:
- vga_clk  in  1  pixel clock.
- rst  in  1  synchronous, active-high reset.
- vga_hsync_in  in  1  hsync from sync generator, active low.
- vga_vsync_in  in  1  vsync from sync generator, active low.
- vga_video_on_in  in  1  visible pixel this cycle.
- mem_req_valid  out  1  read request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  ADDRW  read word address.
- mem_rsp_valid  in  1  read data valid; responses return in request order.
- mem_rsp_data  in  3*COLORW  read pixel.
- vga_r / vga_g / vga_b  out  COLORW each  registered colour.
- vga_hsync / vga_vsync  out  1  inputs delayed by one cycle.
- vga_blank_n  out  1  registered vga_video_on_in; low means blank.
- underflow  out  1  one-cycle pulse: pixel popped while FIFO empty.
- underflow_sticky  out  1  set by underflow; cleared at frame restart.

Behaviour:
- Reset values:
  - mem_req_valid=0, mem_req_addr=BASE_ADDR.
  - RGB=0, vga_hsync=1, vga_vsync=1, vga_blank_n=0.
  - underflow=0, underflow_sticky=0.
  - FIFO empty, outstanding=0, req_cnt=0, state=IDLE.
- Frame start event (fs): registered vsync_in =1 while vsync_in =0, i.e. the falling edge.
- FSM:
  - IDLE: on fs -> FLUSH.
  - FLUSH:
    - No new requests are issued.
    - A request already valid is held until accepted; it counts as outstanding.
    - Responses are discarded.
    - Exit -> FETCH when outstanding==0 and no request pending.
    - On exit: FIFO cleared, mem_req_addr=BASE_ADDR, req_cnt=0, underflow_sticky=0.
  - FETCH:
    - Raise mem_req_valid when count+outstanding < FIFO_DEPTH and req_cnt < FRAME_PIXELS.
    - Once raised, valid and addr are held stable until accepted (mem_req_valid & mem_req_ready).
    - On accept: addr+1, req_cnt+1, outstanding+1.
    - When req_cnt reaches FRAME_PIXELS and no request is pending -> DONE.
    - fs -> FLUSH.
  - DONE: responses still pushed into FIFO; fs -> FLUSH.
- Outstanding bookkeeping:
  - Decrements on every mem_rsp_valid, in any state.
  - Accept and response in the same cycle leave outstanding unchanged.
- Push: mem_rsp_valid in FETCH or DONE. The credit rule guarantees no overflow; an overflow is a design error, and the bench asserts on it.
- Pop: vga_video_on_in=1 and FIFO non-empty.
  - Next cycle RGB = popped pixel.
  - Push and pop in the same cycle leave count unchanged.
  - A push into an empty FIFO is not poppable in that same cycle (no fall-through).
- Underflow: vga_video_on_in=1 while FIFO empty, or in IDLE/FLUSH state.
  - Next cycle RGB=0, underflow=1, underflow_sticky=1.
  - Nothing is popped.
- Blanking: vga_video_on_in=0 gives RGB=0 next cycle.
- Output latency:
  - vga_hsync, vga_vsync, vga_blank_n and RGB all change exactly 1 cycle after the inputs.
  - Relative alignment of sync inputs is preserved.
- fs arriving mid-frame in FETCH or DONE:
  - Pixels remaining in the FIFO are dropped.
  - The next frame restarts at BASE_ADDR.
- Reset mid-operation:
  - All state returns to reset values immediately.
  - Responses for pre-reset requests that arrive before the next fs are ignored: the FSM is in IDLE and discards them.
  - The memory must drain within the vsync pulse.

Test Plan:
- Zero-latency memory (ready=1, rsp 1 cycle after accept, data=address); 640x480 timing for 2 frames -> RGB in visible area equals the pixel index 0..307199 in raster order; underflow_sticky=0; vga_blank_n mirrors video_on delayed 1.
- Random mem_req_ready (50%) and response latency 1-8 cycles, FIFO_DEPTH=16 -> outstanding+count never exceeds 16; no underflow; addresses strictly sequential; valid and addr stable while ready=0.
- Response stall of 40 cycles at pixel 1000 -> underflow pulses while video_on and FIFO empty; RGB=0 for those cycles; sticky stays 1 until next fs, then clears.
- fs forced mid-frame at pixel 5000 with 3 outstanding requests -> FLUSH discards 3 responses; first pixel of new frame from BASE_ADDR; no FIFO overflow.
- Reset asserted in FETCH with a pending request -> next-cycle outputs at reset values; after fs, first request addr=BASE_ADDR.
- Sync passthrough: hsync_in/vsync_in toggles -> outputs identical, delayed exactly 1 cycle, including cycles where video_on=0.
